// File: rtl/serdes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serdes_pkg
//  Description : Shared types and helpers for the serializer/deserializer pair.
//                Holds the assembly state encoding and the length-field width
//                helper used by both sides of the link.
//  Revision    : 1.0 - initial release
// ============================================================================
package serdes_pkg;

  // Assembly state: waiting for the first bit of a run, or mid-word.
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } serdes_state_e;

  // Width of a length field that must encode every value 0..data_w inclusive.
  function automatic int len_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : deserializer
//  Description : Reassembles an MSB-first serial bitstream into left-aligned
//                parallel words. A word ends when the valid strobe drops or
//                when DATA_W bits have been collected; runs shorter than
//                MIN_LEN are discarded and flagged instead of emitted.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_i            in   clock
//    arst_i           in   asynchronous active-high reset
//    ser_data_i       in   serial data bit, MSB first
//    ser_data_val_i   in   bit-valid strobe
//    deser_data_o     out  assembled word, first bit at [DATA_W-1], low bits 0
//    deser_data_len_o out  number of valid bits in deser_data_o (1..DATA_W)
//    deser_data_val_o out  one-cycle pulse, word and length valid
//    drop_o           out  one-cycle pulse, short run discarded
//    busy_o           out  a word is partially collected
// ============================================================================
module deserializer
  import serdes_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int LEN_W   = len_width(DATA_W),
  parameter int MIN_LEN = 1
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [LEN_W-1:0]  deser_data_len_o,
  output logic              deser_data_val_o,
  output logic              drop_o,
  output logic              busy_o
);

  localparam logic [LEN_W-1:0] c_last = LEN_W'(DATA_W - 1);
  localparam logic [LEN_W-1:0] c_full = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] c_one  = LEN_W'(1);

  serdes_state_e     state_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  len_q;
  logic              val_q;
  logic              drop_q;

  // Incoming bit placed at its final position: MSB slot shifted down by the
  // number of bits already collected. With cnt == DATA_W-1 it lands in [0].
  logic [DATA_W-1:0] w_msb;
  logic [DATA_W-1:0] w_ins;

  always_comb begin
    w_msb           = '0;
    w_msb[DATA_W-1] = ser_data_i;
    w_ins           = w_msb >> cnt_q;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      val_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      val_q  <= 1'b0;
      drop_q <= 1'b0;
      if (ser_data_val_i) begin
        // cnt is 0 in IDLE, so this single test also covers DATA_W == 1,
        // where every bit is a complete word on its own.
        if (cnt_q == c_last) begin
          data_q  <= buf_q | w_ins;
          len_q   <= c_full;
          val_q   <= 1'b1;
          buf_q   <= '0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end else begin
          buf_q   <= buf_q | w_ins;
          cnt_q   <= cnt_q + c_one;
          state_q <= COLLECT;
        end
      end else if (state_q == COLLECT) begin
        // Run ended on a partial word.
        if (int'(cnt_q) >= MIN_LEN) begin
          data_q <= buf_q;
          len_q  <= cnt_q;
          val_q  <= 1'b1;
        end else begin
          drop_q <= 1'b1;
        end
        buf_q   <= '0;
        cnt_q   <= '0;
        state_q <= IDLE;
      end
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_len_o = len_q;
  assign deser_data_val_o = val_q;
  assign drop_o           = drop_q;
  assign busy_o           = (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deserializer
//  Description : Scoreboard bench for deserializer. Two instances share the
//                serial input: u1 with MIN_LEN=1 and u4 with MIN_LEN=4. A
//                bench-side model of the serial word assembly pushes expected
//                words/drops with their due cycle; monitors pop and compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer;

  localparam int c_dw = 16;
  localparam int c_lw = 5;

  logic clk;
  logic arst;
  logic ser_data;
  logic ser_val;

  logic [c_dw-1:0] data1, data4;
  logic [c_lw-1:0] len1, len4;
  logic            val1, val4, drop1, drop4, busy1, busy4;

  deserializer #(.DATA_W(c_dw), .MIN_LEN(1)) u1 (
    .clk_i(clk), .arst_i(arst), .ser_data_i(ser_data), .ser_data_val_i(ser_val),
    .deser_data_o(data1), .deser_data_len_o(len1), .deser_data_val_o(val1),
    .drop_o(drop1), .busy_o(busy1)
  );

  deserializer #(.DATA_W(c_dw), .MIN_LEN(4)) u4 (
    .clk_i(clk), .arst_i(arst), .ser_data_i(ser_data), .ser_data_val_i(ser_val),
    .deser_data_o(data4), .deser_data_len_o(len4), .deser_data_val_o(val4),
    .drop_o(drop4), .busy_o(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  len;
    int          due;
    bit          drop;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- bench model of word assembly ----------------
  logic [15:0] m_word = '0;
  int          m_cnt  = 0;

  task automatic push_word(input int due);
    exp_t e;
    e.data = m_word;
    e.len  = 5'(m_cnt);
    e.due  = due;
    e.drop = 1'b0;
    q1.push_back(e);
    e.drop = (m_cnt < 4);
    q4.push_back(e);
    m_word = '0;
    m_cnt  = 0;
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    ser_data = b;
    ser_val  = 1'b1;
    m_word[15 - m_cnt] = b;
    m_cnt++;
    if (m_cnt == 16) push_word(cyc + 1);
  endtask

  task automatic drive_idle();
    @(negedge clk);
    ser_val  = 1'b0;
    ser_data = 1'($urandom);
    if (m_cnt > 0) push_word(cyc + 1);
  endtask

  task automatic drive_run(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(bits[i]);
    drive_idle();
  endtask

  // ---------------- monitors ----------------
  logic [15:0] l4_data = '0;
  logic [4:0]  l4_len  = '0;

  always @(negedge clk) begin
    if (!arst) begin
      chk("u1_no_drop", {31'b0, drop1}, 32'd0);
      if (val1) begin
        chk("u1_val_expected", {31'b0, (q1.size() != 0)}, 32'd1);
        if (q1.size() != 0) begin
          exp_t e;
          e = q1.pop_front();
          chk("u1_data", {16'b0, data1}, {16'b0, e.data});
          chk("u1_len", {27'b0, len1}, {27'b0, e.len});
          chk("u1_latency", cyc, e.due);
          chk("u1_busy_at_pulse", {31'b0, busy1}, 32'd0);
        end
      end
      if (val4 || drop4) begin
        chk("u4_pulse_expected", {31'b0, (q4.size() != 0)}, 32'd1);
        if (q4.size() != 0) begin
          exp_t e;
          e = q4.pop_front();
          chk("u4_val_drop", {30'b0, val4, drop4}, {30'b0, !e.drop, e.drop});
          chk("u4_latency", cyc, e.due);
          chk("u4_busy_at_pulse", {31'b0, busy4}, 32'd0);
          if (e.drop) begin
            chk("u4_hold_data", {16'b0, data4}, {16'b0, l4_data});
            chk("u4_hold_len", {27'b0, len4}, {27'b0, l4_len});
          end else begin
            chk("u4_data", {16'b0, data4}, {16'b0, e.data});
            chk("u4_len", {27'b0, len4}, {27'b0, e.len});
            l4_data = e.data;
            l4_len  = e.len;
          end
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data1"}, {16'b0, data1}, 32'd0);
    chk({tag, "_len1"},  {27'b0, len1},  32'd0);
    chk({tag, "_val1"},  {31'b0, val1},  32'd0);
    chk({tag, "_drop4"}, {31'b0, drop4}, 32'd0);
    chk({tag, "_busy1"}, {31'b0, busy1}, 32'd0);
    chk({tag, "_data4"}, {16'b0, data4}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] w;
    int          n;

    arst     = 1'b1;
    ser_data = 1'b0;
    ser_val  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    arst = 1'b0;
    repeat (2) @(negedge clk);

    // Full word
    drive_run(64'hA5C3, 16);
    repeat (2) drive_idle();

    // Short word 1,0,1,1,0
    drive_run(64'b10110, 5);
    repeat (2) drive_idle();

    // Long run: 0xFFFF then 1,0,0,1
    drive_run({44'b0, 16'hFFFF, 4'b1001}, 20);
    repeat (2) drive_idle();

    // Another full word so outputs hold non-zero values going into reset
    drive_run(64'h5A3C, 16);
    drive_idle();

    // Asynchronous reset mid-word after 5 ones
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    @(negedge clk);
    chk("busy_before_reset", {31'b0, busy1}, 32'd1);
    arst    = 1'b1;
    ser_val = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    m_word  = '0;
    m_cnt   = 0;
    l4_data = '0;
    l4_len  = '0;
    @(negedge clk);
    arst = 1'b0;
    drive_run(64'h1234, 16);
    drive_idle();

    // Drop boundary on u4 (MIN_LEN=4): 3 bits drop, 4 bits emit, 1 bit drop
    drive_run(64'b101, 3);
    drive_idle();
    drive_run(64'b1101, 4);
    drive_idle();
    drive_run(64'b1, 1);
    drive_idle();

    // Loopback-style traffic: random words, mostly back-to-back
    for (int k = 0; k < 30; k++) begin
      w = 16'($urandom);
      for (int b = 15; b >= 0; b--) drive_bit(w[b]);
      if ($urandom_range(0, 2) == 0) drive_idle();
    end
    drive_idle();

    // Random run lengths across word boundaries
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 40);
      for (int b = 0; b < n; b++) drive_bit(1'($urandom));
      drive_idle();
    end

    repeat (4) drive_idle();
    chk("u1_queue_drained", q1.size(), 32'd0);
    chk("u4_queue_drained", q4.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
